// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] divider: a = q*v ^ r. Latency DW+2 (DW+3 with GF2_DIV_OUT_PIPE_EN), v==0 -> 2 (3).
// No backpressure: start is taken only while busy=0 and dropped otherwise; results hold until the next start.
module gf2_poly_divider #(
  parameter int DW = 343,
  parameter int VW = 192
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] v,
  output logic          busy,
  output logic          done,
  output logic          div0,
  output logic [DW-1:0] q,
  output logic [VW-2:0] r
);

  localparam int DEGW = (VW > 2) ? $clog2(VW) : 1;
  localparam int CW   = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   a_sh;
  logic [VW-2:0]   v_reg;
  logic [DEGW-1:0] deg_reg;
  logic [DEGW-1:0] deg_c;
  logic [VW-2:0]   r_reg;
  logic [DW-1:0]   q_reg;
  logic [CW-1:0]   cnt;
  logic            busy_reg;
  logic            accept;
  logic            v_zero;
  logic [VW-1:0]   r_shift;
  logic            hit;

  logic [DW-1:0]   q_s;
  logic [VW-2:0]   r_s;
  logic            div0_s;
  logic            done_s;

  always_comb begin
    deg_c = '0;
    for (int i = 0; i < VW; i++) begin
      if (v[i]) deg_c = DEGW'(i);
    end
  end

  assign v_zero = ~|v;
  assign accept = start && (state != DIV);

  // Stored R stays below 2^deg, so R and V only need their low VW-1 bits:
  // the bit at deg cancels on a hit and everything above it is zero.
  assign r_shift = {r_reg, a_sh[DW-1]};
  assign hit     = r_shift[deg_reg];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = v_zero ? FIN : DIV;
      DIV:  if (cnt == CW'(DW - 1)) state_nxt = FIN;
      FIN:  begin
        if (accept) state_nxt = v_zero ? FIN : DIV;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh     <= '0;
      v_reg    <= '0;
      deg_reg  <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      q_s      <= '0;
      r_s      <= '0;
      div0_s   <= 1'b0;
      done_s   <= 1'b0;
    end else begin
      if (accept) begin
        a_sh    <= a;
        v_reg   <= v[VW-2:0];
        deg_reg <= deg_c;
        r_reg   <= '0;
        q_reg   <= '0;
        cnt     <= '0;
        div0_s  <= v_zero;
      end else if (state == DIV) begin
        a_sh  <= {a_sh[DW-2:0], 1'b0};
        r_reg <= r_shift[VW-2:0] ^ (hit ? v_reg : '0);
        q_reg <= {q_reg[DW-2:0], hit};
        cnt   <= cnt + 1'b1;
      end

      busy_reg <= (state_nxt == DIV);
      done_s   <= (state == FIN);
      // FIN publishes the old Q/R even when a new start is captured on the same edge.
      if (state == FIN) begin
        q_s <= q_reg;
        r_s <= r_reg;
      end
    end
  end

  assign busy = busy_reg;

`ifdef GF2_DIV_OUT_PIPE_EN
  logic [DW-1:0] q_p;
  logic [VW-2:0] r_p;
  logic          div0_p;
  logic          done_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_p    <= '0;
      r_p    <= '0;
      div0_p <= 1'b0;
      done_p <= 1'b0;
    end else begin
      q_p    <= q_s;
      r_p    <= r_s;
      div0_p <= div0_s;
      done_p <= done_s;
    end
  end

  assign q    = q_p;
  assign r    = r_p;
  assign div0 = div0_p;
  assign done = done_p;
`else
  assign q    = q_s;
  assign r    = r_s;
  assign div0 = div0_s;
  assign done = done_s;
`endif

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed bench for gf2_poly_divider: vector table, corner sequences, clmul round trips.
module tb_gf2_poly_divider;

  localparam int DW = 343;
  localparam int VW = 192;
`ifdef GF2_DIV_OUT_PIPE_EN
  localparam int LAT  = DW + 3;
  localparam int LAT0 = 3;
`else
  localparam int LAT  = DW + 2;
  localparam int LAT0 = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] v;
  logic          busy;
  logic          done;
  logic          div0;
  logic [DW-1:0] q;
  logic [VW-2:0] r;

  int checks = 0;
  int errors = 0;

  gf2_poly_divider #(.DW(DW), .VW(VW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .v    (v),
    .busy (busy),
    .done (done),
    .div0 (div0),
    .q    (q),
    .r    (r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [VW-1:0] v;
    logic [DW-1:0] q;
    logic [VW-2:0] r;
    logic          d0;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] aa, input logic [VW-1:0] vv,
                              input logic [DW-1:0] qq, input logic [VW-2:0] rr, input logic dd);
    vec_t t;
    t.a  = aa;
    t.v  = vv;
    t.q  = qq;
    t.r  = rr;
    t.d0 = dd;
    return t;
  endfunction

  function automatic logic [DW-1:0] clmul(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < VW; i++) begin
      if (x[i]) p = p ^ (DW'(y) << i);
    end
    return p;
  endfunction

  // Pulse start for one cycle, then count negedges until done (bounded).
  task automatic run_op(input logic [DW-1:0] aa, input logic [VW-1:0] vv, output int lat);
    @(negedge clk);
    a = aa;
    v = vv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [DW-1:0] big, atop, p;
    logic [VW-1:0] vtop, x, y, z;
    int lat, n, seen;

    big = '0;
    big[DW-1] = 1'b1;
    big[0] = 1'b1;
    vtop = '0;
    vtop[VW-1] = 1'b1;
    atop = '0;
    atop[200] = 1'b1;
    atop[2:0] = 3'b111;

    tv[0] = mk(DW'(32'h11),  VW'(32'h3),   DW'(32'hF),   (VW-1)'(32'h0),  1'b0);
    tv[1] = mk(DW'(32'h1F),  VW'(32'h7),   DW'(32'h4),   (VW-1)'(32'h3),  1'b0);
    tv[2] = mk(DW'(32'h5),   VW'(32'h1),   DW'(32'h5),   (VW-1)'(32'h0),  1'b0);
    tv[3] = mk(DW'(32'h5),   VW'(32'h10),  DW'(32'h0),   (VW-1)'(32'h5),  1'b0);
    tv[4] = mk(DW'(32'h100), VW'(32'h11B), DW'(32'h1),   (VW-1)'(32'h1B), 1'b0);
    tv[5] = mk(DW'(32'h2B),  VW'(32'h5),   DW'(32'h8),   (VW-1)'(32'h3),  1'b0);
    tv[6] = mk(big,          VW'(32'h1),   big,          (VW-1)'(32'h0),  1'b0);
    tv[7] = mk(atop,         vtop,         DW'(32'h200), (VW-1)'(32'h7),  1'b0);
    tv[8] = mk(DW'(32'h123), VW'(32'h0),   DW'(32'h0),   (VW-1)'(32'h0),  1'b1);
    tv[9] = mk(DW'(32'h11),  VW'(32'h3),   DW'(32'hF),   (VW-1)'(32'h0),  1'b0);

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    v = '0;
    repeat (3) @(negedge clk);
    chk_b("reset busy", busy, 1'b0);
    chk_b("reset done", done, 1'b0);
    chk_b("reset div0", div0, 1'b0);
    chk("reset q", q, '0);
    chk("reset r", DW'(r), '0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].a, tv[i].v, lat);
      chk_i($sformatf("vec%0d latency", i), lat, tv[i].d0 ? LAT0 : LAT);
      chk($sformatf("vec%0d q", i), q, tv[i].q);
      chk($sformatf("vec%0d r", i), DW'(r), DW'(tv[i].r));
      chk_b($sformatf("vec%0d div0", i), div0, tv[i].d0);
      chk_b($sformatf("vec%0d busy at done", i), busy, 1'b0);
      @(negedge clk);
      chk_b($sformatf("vec%0d done pulse", i), done, 1'b0);
    end

    // Start pulsed mid-division is dropped.
    @(negedge clk);
    a = DW'(32'h1F);
    v = VW'(32'h7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (10) begin
      @(negedge clk);
      lat++;
    end
    a = DW'(32'h11);
    v = VW'(32'h3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat++;
    chk_b("ignored start busy", busy, 1'b1);
    while (done !== 1'b1 && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
    end
    chk_i("ignored start latency", lat, LAT);
    chk("ignored start q", q, DW'(32'h4));
    chk("ignored start r", DW'(r), DW'(32'h3));

    // Asynchronous reset mid-division clears everything and suppresses done.
    @(negedge clk);
    a = DW'(32'h2B);
    v = VW'(32'h5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("mid reset busy", busy, 1'b0);
    chk_b("mid reset done", done, 1'b0);
    chk_b("mid reset div0", div0, 1'b0);
    chk("mid reset q", q, '0);
    chk("mid reset r", DW'(r), '0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk_i("no done after reset", seen, 0);

    // Start accepted in FIN while the previous result drains.
    @(negedge clk);
    a = DW'(32'h1F);
    v = VW'(32'h7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (busy !== 1'b0 && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    a = DW'(32'h2B);
    v = VW'(32'h5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_b("fin start first done", done, 1'b1);
    chk("fin start first q", q, DW'(32'h4));
    chk("fin start first r", DW'(r), DW'(32'h3));
    chk_b("fin start accepted", busy, 1'b1);
    @(negedge clk);
    lat++;
    while (done !== 1'b1 && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
    end
    chk_i("fin start latency", lat, LAT);
    chk("fin start second q", q, DW'(32'h8));
    chk("fin start second r", DW'(r), DW'(32'h3));

    // Start held high in the done cycle itself.
    a = DW'(32'h100);
    v = VW'(32'h11B);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
    end
    chk_i("done-cycle start latency", lat, LAT);
    chk("done-cycle start q", q, DW'(32'h1));
    chk("done-cycle start r", DW'(r), DW'(32'h1B));

    // Round trip against a carry-less product.
    for (int t = 0; t < 2; t++) begin
      x = '0;
      y = '0;
      z = '0;
      for (int k = 0; k < VW; k += 32) begin
        x[k +: 32] = $urandom();
        y[k +: 32] = $urandom();
        z[k +: 32] = $urandom();
      end
      y[VW-1:151] = '0;
      y[150] = 1'b1;
      z[VW-1:150] = '0;
      p = clmul(x, y);
      run_op(p, y, lat);
      chk_i($sformatf("rt%0d latency", t), lat, LAT);
      chk($sformatf("rt%0d q", t), q, DW'(x));
      chk($sformatf("rt%0d r", t), DW'(r), '0);
      run_op(p ^ DW'(z), y, lat);
      chk($sformatf("rt%0d+z q", t), q, DW'(x));
      chk($sformatf("rt%0d+z r", t), DW'(r), DW'(z));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
